// File: rtl/bnn_seq_classifier.sv
// bnn_seq_classifier: time-multiplexed binary neural network classifier.
// Evaluates one hidden neuron per cycle, then one output neuron per cycle, and reports the argmax class.
module bnn_seq_classifier #(
  parameter int N_IN  = 16,
  parameter int N_HID = 8,
  parameter int N_CLS = 4,
  localparam int TH_W  = $clog2(N_IN + 1),
  localparam int CLS_W = $clog2(N_CLS),
  localparam int SC_W  = $clog2(N_HID + 1),
  parameter logic [N_HID*N_IN-1:0]  W_IH = {N_HID*N_IN{1'b1}},
  parameter logic [N_HID*TH_W-1:0]  TH_H = {N_HID{TH_W'(N_IN/2)}},
  parameter logic [N_CLS*N_HID-1:0] W_HO = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [N_IN-1:0]  feat_in,
  output logic             busy,
  output logic             done,
  output logic [CLS_W-1:0] class_out,
  output logic [SC_W-1:0]  score_out,
  output logic [N_HID-1:0] hidden_out
);

  localparam int IDX_N = (N_HID > N_CLS) ? N_HID : N_CLS;
  localparam int IDX_W = $clog2(IDX_N);
  localparam logic [IDX_W-1:0] LAST_H = IDX_W'(N_HID - 1);
  localparam logic [IDX_W-1:0] LAST_C = IDX_W'(N_CLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIDDEN,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [N_IN-1:0]    x;
  logic [N_HID-1:0]   hid;
  logic [CLS_W-1:0]   best;
  logic [SC_W-1:0]    best_sc;

  logic [N_IN-1:0]    w_ih_row;
  logic [TH_W-1:0]    th_row;
  logic [N_HID-1:0]   w_ho_row;
  logic               hid_bit;
  logic [SC_W-1:0]    sc;
  logic               take;
  logic [CLS_W-1:0]   cand_cls;
  logic [SC_W-1:0]    cand_sc;

  function automatic logic [TH_W-1:0] pop_in(input logic [N_IN-1:0] v);
    logic [TH_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + TH_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SC_W-1:0] pop_hid(input logic [N_HID-1:0] v);
    logic [SC_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_HID; i++) c = c + SC_W'(v[i]);
    return c;
  endfunction

  // Both neuron layers share one XNOR-popcount datapath, row-selected by idx.
  // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_ih_row = W_IH[int'(idx)*N_IN +: N_IN];
    th_row   = TH_H[int'(idx)*TH_W +: TH_W];
    w_ho_row = W_HO[int'(idx)*N_HID +: N_HID];
    hid_bit  = pop_in(~(x ^ w_ih_row)) >= th_row;
    sc       = pop_hid(~(hid ^ w_ho_row));
    // Strict compare keeps the earliest (lowest-index) class on ties.
    take     = (idx == '0) || (sc > best_sc);
    cand_cls = take ? CLS_W'(idx) : best;
    cand_sc  = take ? sc : best_sc;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      x          <= '0;
      hid        <= '0;
      best       <= '0;
      best_sc    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      class_out  <= '0;
      score_out  <= '0;
      hidden_out <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            x     <= feat_in;
            idx   <= '0;
            hid   <= '0;
            busy  <= 1'b1;
            state <= S_HIDDEN;
          end
        end
        S_HIDDEN: begin
          hid[idx] <= hid_bit;
          if (idx == LAST_H) begin
            idx     <= '0;
            best    <= '0;
            best_sc <= '0;
            state   <= S_OUTPUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_OUTPUT: begin
          best    <= cand_cls;
          best_sc <= cand_sc;
          if (idx == LAST_C) begin
            // Result registers load with the final candidate, so they are valid with done.
            class_out  <= cand_cls;
            score_out  <= cand_sc;
            hidden_out <= hid;
            done       <= 1'b1;
            idx        <= '0;
            state      <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Self-checking bench for bnn_seq_classifier: three configurations driven in lockstep,
// results checked against a scoreboard filled when each start is issued.
module tb_bnn_seq_classifier;

  localparam logic [127:0] C_W_IH = {16'hFFFF, 16'h1234, 16'h5555, 16'hAAAA,
                                     16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0};
  localparam logic [7:0]   C_ROW  = 8'h36;

  logic        clk = 1'b0;
  logic        rst_n, ena, start;
  logic [15:0] feat_in;

  logic       busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [1:0] class_a, class_b, class_c;
  logic [3:0] score_a, score_b, score_c;
  logic [7:0] hidden_a, hidden_b, hidden_c;

  // Config A: default hidden layer, only output row 2 all-ones.
  bnn_seq_classifier #(.W_HO(32'h00FF_0000)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .feat_in(feat_in),
    .busy(busy_a), .done(done_a), .class_out(class_a), .score_out(score_a),
    .hidden_out(hidden_a));

  // Config B: unreachable thresholds, output row 1 all-zeros, others all-ones.
  bnn_seq_classifier #(.TH_H({8{5'd17}}), .W_HO(32'hFFFF_00FF)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .feat_in(feat_in),
    .busy(busy_b), .done(done_b), .class_out(class_b), .score_out(score_b),
    .hidden_out(hidden_b));

  // Config C: mixed hidden weights, all output rows identical.
  bnn_seq_classifier #(.W_IH(C_W_IH), .W_HO({4{C_ROW}})) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .feat_in(feat_in),
    .busy(busy_c), .done(done_c), .class_out(class_c), .score_out(score_c),
    .hidden_out(hidden_c));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hid_a;
    logic [1:0] cls_a;
    logic [7:0] hid_c;
    logic [3:0] sc_c;
  } exp_t;

  typedef struct {
    logic [15:0] feat;
    logic [7:0]  hid_a;
    logic [1:0]  cls_a;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_hid_c(input logic [15:0] f);
    logic [7:0] h;
    for (int i = 0; i < 8; i++) h[i] = $countones(~(f ^ C_W_IH[i*16 +: 16])) >= 8;
    return h;
  endfunction

  task automatic push_exp(input logic [15:0] f, input logic [7:0] ha, input logic [1:0] ca);
    exp_t e;
    e.hid_a = ha;
    e.cls_a = ca;
    e.hid_c = model_hid_c(f);
    e.sc_c  = 4'($countones(~(e.hid_c ^ C_ROW)));
    sb.push_back(e);
  endtask

  // Every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done_a) begin
      done_cnt++;
      check("done_b_sync", done_b, 1);
      check("done_c_sync", done_c, 1);
      check("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e_mon = sb.pop_front();
        check("hidden_a", hidden_a, e_mon.hid_a);
        check("class_a", class_a, e_mon.cls_a);
        check("score_a", score_a, 4'd8);
        check("hidden_b", hidden_b, 8'h00);
        check("class_b", class_b, 2'd1);
        check("score_b", score_b, 4'd8);
        check("hidden_c", hidden_c, e_mon.hid_c);
        check("class_c", class_c, 2'd0);
        check("score_c", score_c, e_mon.sc_c);
      end
    end
  end

  // Issues one start, optionally stalls and pokes start while busy; returns cycles to done.
  task automatic run_one(input logic [15:0] f, input logic [7:0] ha, input logic [1:0] ca,
                         input int stall_at, input int stall_n, input bit poke, output int lat);
    @(negedge clk);
    push_exp(f, ha, ca);
    feat_in = f;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check("busy_after_start", busy_a, 1);
    while (!done_a && lat < 60) begin
      ena     = !(lat >= stall_at && lat < stall_at + stall_n);
      start   = poke && (lat % 3 == 0);
      feat_in = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    ena = 1'b1;
    check("done_seen", done_a, 1);
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done_a, 0);
    check("busy_back_idle", busy_a, 0);
  endtask

  initial begin
    int lat, cnt0, first, second;
    logic [15:0] f;

    vecs[0] = '{16'hFFFF, 8'hFF, 2'd2};
    vecs[1] = '{16'h0000, 8'h00, 2'd0};
    vecs[2] = '{16'h00FF, 8'hFF, 2'd2};
    vecs[3] = '{16'h007F, 8'h00, 2'd0};
    vecs[4] = '{16'h1234, 8'h00, 2'd0};
    vecs[5] = '{16'hF0F1, 8'hFF, 2'd2};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; feat_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_class", class_a, 0);
    check("rst_score", score_a, 0);
    check("rst_hidden", hidden_a, 0);
    check("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_one(vecs[i].feat, vecs[i].hid_a, vecs[i].cls_a, 0, 0, 1'b0, lat);
      check("latency", lat, 13);
    end

    for (int i = 0; i < 4; i++) begin
      f = 16'($urandom);
      run_one(f, ($countones(f) >= 8) ? 8'hFF : 8'h00,
              ($countones(f) >= 8) ? 2'd2 : 2'd0, 0, 0, 1'b0, lat);
      check("latency_rand", lat, 13);
    end

    // Three stalled cycles mid-HIDDEN plus start pokes while busy.
    cnt0 = done_cnt;
    run_one(16'hFFFF, 8'hFF, 2'd2, 3, 3, 1'b1, lat);
    check("latency_stall", lat, 16);
    repeat (20) @(negedge clk);
    check("single_done_stall", done_cnt - cnt0, 1);

    // Asynchronous reset in the middle of an inference.
    @(negedge clk);
    feat_in = 16'hFFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    cnt0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy_a, 0);
    check("arst_class", class_a, 0);
    check("arst_score", score_a, 0);
    check("arst_hidden", hidden_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", done_cnt - cnt0, 0);
    run_one(16'hFFFF, 8'hFF, 2'd2, 0, 0, 1'b0, lat);
    check("latency_post_rst", lat, 13);

    // Back-to-back with start held high; the second capture sees the new features.
    @(negedge clk);
    push_exp(16'hFFFF, 8'hFF, 2'd2);
    push_exp(16'h0000, 8'h00, 2'd0);
    feat_in = 16'hFFFF;
    start   = 1'b1;
    first   = 0;
    second  = 0;
    for (int k = 1; k <= 40 && second == 0; k++) begin
      @(negedge clk);
      if (k == 1) feat_in = 16'h0000;
      if (done_a) begin
        if (first == 0) first = k;
        else begin
          second = k;
          start  = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_done", first, 13);
    check("b2b_second_done", second, 27);

    repeat (20) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
